// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash path: byte-engine FSM states, SPI mode
// numbers, and the flash opcodes used by spi_flash_reader.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int MODE0 = 0;
    localparam int MODE1 = 1;
    localparam int MODE2 = 2;
    localparam int MODE3 = 3;

    localparam logic [7:0] OP_WAKEUP = 8'hAB;
    localparam logic [7:0] OP_READ   = 8'h03;

    // Clock polarity: modes 2 and 3 idle spi_clk high.
    function automatic logic mode_cpol(input int mode);
        return (mode == MODE2) || (mode == MODE3);
    endfunction

    // Clock phase: modes 1 and 3 change data on the leading edge.
    function automatic logic mode_cpha(input int mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Byte-level SPI master. Shifts one byte out on spi_mosi and one byte in from
// spi_miso per transfer, with spi_clk derived from clk by a half-bit counter.
// Chip-select belongs to the upstream reader, so it is not handled here.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = MODE0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic CPOL = mode_cpol(SPI_MODE);
    localparam logic CPHA = mode_cpha(SPI_MODE);
    localparam int   HC_W = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam logic [HC_W-1:0] HALF_RELOAD = HC_W'(CLKS_PER_HALF_BIT - 1);

    generate
        if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_mode
            $error("spi_byte_engine: SPI_MODE must be in 0..3");
        end
        if (CLKS_PER_HALF_BIT < 1) begin : g_bad_div
            $error("spi_byte_engine: CLKS_PER_HALF_BIT must be at least 1");
        end
    endgenerate

    spi_state_t      state;
    logic [7:0]      tx_shift;
    logic [7:0]      rx_shift;
    logic [4:0]      edge_cnt;
    logic [HC_W-1:0] half_cnt;

    logic            leading_edge;
    logic            last_edge;
    logic            sample_now;
    logic            shift_now;
    logic            mosi_next;
    logic [7:0]      rx_next;

    // Classify the upcoming spi_clk edge; edges count down 16..1, so an even
    // count is a leading edge and edge 1 is the final trailing edge.
    always_comb begin
        leading_edge = ~edge_cnt[0];
        last_edge    = (edge_cnt == 5'd1);
        sample_now   = CPHA ? ~leading_edge : leading_edge;
        shift_now    = CPHA ? leading_edge : (~leading_edge && !last_edge);
        mosi_next    = CPHA ? tx_shift[7] : tx_shift[6];
        rx_next      = {rx_shift[6:0], spi_miso};
    end

    // Transfer FSM: accept a byte in IDLE, then walk 16 spi_clk edges in ACTIVE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
            busy     <= 1'b0;
            spi_clk  <= CPOL;
            spi_mosi <= 1'b0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            edge_cnt <= 5'd0;
            half_cnt <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_byte;
                        edge_cnt <= 5'd16;
                        half_cnt <= HALF_RELOAD;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (!CPHA) begin
                            spi_mosi <= tx_byte[7];
                        end
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (half_cnt != '0) begin
                        half_cnt <= half_cnt - HC_W'(1);
                    end else begin
                        half_cnt <= HALF_RELOAD;
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= edge_cnt - 5'd1;
                        if (sample_now) begin
                            rx_shift <= rx_next;
                        end
                        if (shift_now) begin
                            spi_mosi <= mosi_next;
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (last_edge) begin
                            rx_byte  <= sample_now ? rx_next : rx_shift;
                            rx_valid <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine. Four instances cover all SPI modes:
// index 0 is mode 0 with a divider of 2, indices 1..3 are modes 1..3 with a
// divider of 1. Each accepted byte pushes its expected rx_byte and due cycle;
// a per-instance monitor pops and compares on every rx_valid pulse.
module tb_spi_byte_engine;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tx_valid = '0;
    logic [3:0] tx_ready;
    logic [3:0] rx_valid;
    logic [3:0] busy;
    logic [3:0] spi_clk;
    logic [3:0] spi_mosi;
    logic [3:0] spi_miso;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
    logic [3:0] loop_en = 4'hF;
    logic [3:0] miso_level = '0;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rise_cnt0 = 0;
    logic [7:0] mosi_hist0 = 8'h00;
    exp_t exp_q [4][$];

    assign spi_miso = (loop_en & spi_mosi) | (~loop_en & miso_level);

    always #5 clk = ~clk;

    // Free-running cycle count used for latency bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;

    // Record the MOSI bit presented at each rising spi_clk edge of instance 0.
    always @(posedge spi_clk[0]) begin
        rise_cnt0  = rise_cnt0 + 1;
        mosi_hist0 = {mosi_hist0[6:0], spi_mosi[0]};
    end

    function automatic int halfOf(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int cpolOf(input int g);
        return (g >= 2) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Instances plus their rx_valid monitors.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_byte_engine #(
            .SPI_MODE          (g),
            .CLKS_PER_HALF_BIT ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_byte  (tx_byte[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .rx_byte  (rx_byte[g]),
            .rx_valid (rx_valid[g]),
            .busy     (busy[g]),
            .spi_clk  (spi_clk[g]),
            .spi_mosi (spi_mosi[g]),
            .spi_miso (spi_miso[g])
        );

        exp_t item;

        // Pop the oldest expectation whenever this instance presents a byte.
        always @(negedge clk) begin
            if (rx_valid[g]) begin
                if (exp_q[g].size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rx dut%0d: got pulse with %02h required no pulse", g, rx_byte[g]);
                end else begin
                    item = exp_q[g].pop_front();
                    checkOutput($sformatf("rx_byte dut%0d", g), int'(rx_byte[g]), int'(item.data));
                    checkOutput($sformatf("rx_latency dut%0d", g), cyc, item.due);
                end
            end
        end
    end

    // Offer a byte until accepted; the accept cycle is returned and the
    // expected response is queued for the monitor.
    task automatic applyStimulus(input int g, input logic [7:0] data, input logic [7:0] want,
                                 input bit hold, output int acc);
        int n = 0;
        @(negedge clk);
        tx_byte[g]  = data;
        tx_valid[g] = 1'b1;
        while (!tx_ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready[g]) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout dut%0d: got tx_ready=0 required 1", g);
            tx_valid[g] = 1'b0;
            acc = cyc;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            exp_q[g].push_back('{data: want, due: cyc + 16 * halfOf(g)});
            if (!hold) tx_valid[g] = 1'b0;
        end
    endtask

    task automatic waitDone(input int g);
        int n = 0;
        while ((exp_q[g].size() != 0 || !tx_ready[g]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[g].size() != 0 || !tx_ready[g]) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_done dut%0d: got pending=%0d required 0", g, exp_q[g].size());
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input int g);
        checkOutput($sformatf("rst_tx_ready dut%0d", g), int'(tx_ready[g]), 1);
        checkOutput($sformatf("rst_rx_valid dut%0d", g), int'(rx_valid[g]), 0);
        checkOutput($sformatf("rst_rx_byte dut%0d", g), int'(rx_byte[g]), 0);
        checkOutput($sformatf("rst_busy dut%0d", g), int'(busy[g]), 0);
        checkOutput($sformatf("rst_spi_clk dut%0d", g), int'(spi_clk[g]), cpolOf(g));
        checkOutput($sformatf("rst_spi_mosi dut%0d", g), int'(spi_mosi[g]), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int acc_b2b [4];
        int rise_before;
        logic [7:0] rd_cmd [4];
        rd_cmd = '{8'h03, 8'h02, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;

        // Reset values on every instance.
        #23;
        for (int i = 0; i < 4; i++) checkReset(i);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] mode 0 loopback 8'hAB");
        rise_before = rise_cnt0;
        applyStimulus(0, 8'hAB, 8'hAB, 1'b0, acc);
        waitDone(0);
        checkOutput("ab_rising_edges", rise_cnt0 - rise_before, 8);
        checkOutput("ab_spi_clk_idle", int'(spi_clk[0]), 0);
        checkOutput("ab_mosi_holds", int'(spi_mosi[0]), 1);

        $display("[TB] mode 0 miso tied high then low, 8'h03");
        loop_en[0] = 1'b0;
        miso_level[0] = 1'b1;
        rise_before = rise_cnt0;
        applyStimulus(0, 8'h03, 8'hFF, 1'b0, acc);
        waitDone(0);
        checkOutput("tied1_rising_edges", rise_cnt0 - rise_before, 8);
        checkOutput("tied1_mosi_bits", int'(mosi_hist0), 8'h03);
        miso_level[0] = 1'b0;
        applyStimulus(0, 8'h03, 8'h00, 1'b0, acc);
        waitDone(0);
        checkOutput("tied0_mosi_bits", int'(mosi_hist0), 8'h03);
        checkOutput("rx_byte_holds", int'(rx_byte[0]), 8'h00);
        loop_en[0] = 1'b1;

        // tx_valid stays high; each accept lands on the edge closing the
        // previous rx_valid cycle, so accepts are 16*N+1 cycles apart.
        $display("[TB] back-to-back flash read command");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, rd_cmd[i], rd_cmd[i], (i != 3), acc);
            acc_b2b[i] = acc;
        end
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("b2b_spacing %0d", i), acc_b2b[i] - acc_b2b[i-1], 33);
        end
        waitDone(0);

        $display("[TB] request while busy is ignored");
        applyStimulus(0, 8'h3C, 8'h3C, 1'b0, acc);
        repeat (5) @(negedge clk);
        checkOutput("busy_mid_transfer", int'(busy[0]), 1);
        checkOutput("ready_mid_transfer", int'(tx_ready[0]), 0);
        tx_byte[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        tx_valid[0] = 1'b0;
        waitDone(0);
        repeat (40) @(negedge clk);
        checkOutput("busy_ignored_mosi", int'(spi_mosi[0]), 0);

        // Pull reset while spi_clk is high, just ahead of edge 7.
        $display("[TB] reset mid-transfer");
        applyStimulus(0, 8'h96, 8'h96, 1'b0, acc);
        repeat (19) @(posedge clk);
        #2;
        checkOutput("pre_rst_spi_clk", int'(spi_clk[0]), 1);
        checkOutput("pre_rst_busy", int'(busy[0]), 1);
        rst = 1'b0;
        exp_q[0].delete();
        #1;
        checkReset(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(0, 8'hC5, 8'hC5, 1'b0, acc);
        waitDone(0);

        $display("[TB] modes 1..3 loopback 8'h5A");
        for (int g = 1; g < 4; g++) begin
            applyStimulus(g, 8'h5A, 8'h5A, 1'b0, acc);
            waitDone(g);
            checkOutput($sformatf("idle_spi_clk dut%0d", g), int'(spi_clk[g]), cpolOf(g));
            checkOutput($sformatf("mosi_holds dut%0d", g), int'(spi_mosi[g]), 0);
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
